// File: rtl/regfile_sb.sv
// Scoreboarded register file: two combinational read ports, one write port, per-register pending bits.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and pending clear to the read ports.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Read_import1,
    input  logic [ADDR_W-1:0] Read_import2,
    output logic [DATA_W-1:0] Rout1,
    output logic [DATA_W-1:0] Rout2,
    output logic              Rbusy1,
    output logic              Rbusy2,
    input  logic [ADDR_W-1:0] Write_import,
    input  logic [DATA_W-1:0] Write_data,
    input  logic              Ctrl_regWr,
    input  logic [ADDR_W-1:0] Issue_import,
    input  logic              Ctrl_issue,
    output logic              Issue_ready,
    output logic [ADDR_W:0]   Pending_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_next;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_next;

    logic wr_en;
    logic issue_acc;
    logic clr_set_bit;

    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              bz1;
    logic              bz2;

    assign wr_en       = Ctrl_regWr && (Write_import != '0);
    assign Issue_ready = (Issue_import == '0) || !pend_q[Issue_import];
    assign issue_acc   = Ctrl_issue && Issue_ready && (Issue_import != '0);
    // An issue to the write target is only accepted when its bit is clear, so no double count.
    assign clr_set_bit = wr_en && pend_q[Write_import];

    always_comb begin
        pend_next = pend_q;
        if (wr_en)
            pend_next[Write_import] = 1'b0;
        if (issue_acc)
            pend_next[Issue_import] = 1'b1;
    end

    always_comb begin
        cnt_next = cnt_q;
        case ({issue_acc, clr_set_bit})
            2'b10:   cnt_next = cnt_q + CNT_ONE;
            2'b01:   cnt_next = cnt_q - CNT_ONE;
            default: cnt_next = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en)
                mem[Write_import] <= Write_data;
            pend_q <= pend_next;
            cnt_q  <= cnt_next;
        end
    end

    always_comb begin
        rd1 = (Read_import1 == '0) ? '0 : mem[Read_import1];
        rd2 = (Read_import2 == '0) ? '0 : mem[Read_import2];
        bz1 = pend_q[Read_import1];
        bz2 = pend_q[Read_import2];
`ifdef REGFILE_BYPASS_EN
        // Same-cycle write wins over storage; a matching accepted issue keeps the register busy.
        if (wr_en && (Read_import1 == Write_import)) begin
            rd1 = Write_data;
            bz1 = issue_acc && (Issue_import == Write_import);
        end
        if (wr_en && (Read_import2 == Write_import)) begin
            rd2 = Write_data;
            bz2 = issue_acc && (Issue_import == Write_import);
        end
`endif
    end

    assign Rout1       = rd1;
    assign Rout2       = rd2;
    assign Rbusy1      = bz1;
    assign Rbusy2      = bz2;
    assign Pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default build; bypass expectations follow REGFILE_BYPASS_EN).
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  Read_import1;
    logic [4:0]  Read_import2;
    logic [31:0] Rout1;
    logic [31:0] Rout2;
    logic        Rbusy1;
    logic        Rbusy2;
    logic [4:0]  Write_import;
    logic [31:0] Write_data;
    logic        Ctrl_regWr;
    logic [4:0]  Issue_import;
    logic        Ctrl_issue;
    logic        Issue_ready;
    logic [5:0]  Pending_cnt;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .Read_import1(Read_import1),
        .Read_import2(Read_import2),
        .Rout1(Rout1),
        .Rout2(Rout2),
        .Rbusy1(Rbusy1),
        .Rbusy2(Rbusy2),
        .Write_import(Write_import),
        .Write_data(Write_data),
        .Ctrl_regWr(Ctrl_regWr),
        .Issue_import(Issue_import),
        .Ctrl_issue(Ctrl_issue),
        .Issue_ready(Issue_ready),
        .Pending_cnt(Pending_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Ctrl_regWr = 1'b0;
        Ctrl_issue = 1'b0;
        Write_import = '0;
        Write_data = '0;
        Issue_import = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        Read_import1 = 5'd5;
        Read_import2 = 5'd0;
        cycle();
        cycle();
        checks++;
        if (Rout1 !== 32'h0 || Rbusy1 !== 1'b0 || Rbusy2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: Rout1=%h Rbusy1=%b Rbusy2=%b required 0/0/0", Rout1, Rbusy1, Rbusy2);
        end
        checks++;
        if (Issue_ready !== 1'b1 || Pending_cnt !== 6'd0) begin
            errors++;
            $display("FAIL reset_state: Issue_ready=%b Pending_cnt=%0d required 1/0", Issue_ready, Pending_cnt);
        end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_write_read();
        Ctrl_regWr = 1'b1; Write_import = 5'd5; Write_data = 32'hDEADBEEF;
        cycle();
        idle();
        Read_import1 = 5'd5;
        #1;
        checks++;
        if (Rout1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_r5: Rout1=%h required deadbeef", Rout1);
        end
        Ctrl_regWr = 1'b1; Write_import = 5'd0; Write_data = 32'h1;
        cycle();
        idle();
        Read_import1 = 5'd0;
        Read_import2 = 5'd0;
        #1;
        checks++;
        if (Rout1 !== 32'h0 || Rout2 !== 32'h0 || Rbusy1 !== 1'b0) begin
            errors++;
            $display("FAIL write_r0: Rout1=%h Rout2=%h Rbusy1=%b required 0/0/0", Rout1, Rout2, Rbusy1);
        end
    endtask

    task automatic test_issue();
        Issue_import = 5'd7; Ctrl_issue = 1'b1;
        #1;
        checks++;
        if (Issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_r7_ready: Issue_ready=%b required 1", Issue_ready);
        end
        cycle();
        Ctrl_issue = 1'b0;
        Read_import1 = 5'd7;
        #1;
        checks++;
        if (Rbusy1 !== 1'b1 || Issue_ready !== 1'b0 || Pending_cnt !== 6'd1) begin
            errors++;
            $display("FAIL issue_r7: Rbusy1=%b Issue_ready=%b Pending_cnt=%0d required 1/0/1", Rbusy1, Issue_ready, Pending_cnt);
        end
        // Issue to r0 is always ready and never counted
        Issue_import = 5'd0; Ctrl_issue = 1'b1;
        #1;
        checks++;
        if (Issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_r0_ready: Issue_ready=%b required 1", Issue_ready);
        end
        cycle();
        Ctrl_issue = 1'b0;
        #1;
        checks++;
        if (Pending_cnt !== 6'd1) begin
            errors++;
            $display("FAIL issue_r0_cnt: Pending_cnt=%0d required 1", Pending_cnt);
        end
        Ctrl_regWr = 1'b1; Write_import = 5'd7; Write_data = 32'h55;
        cycle();
        idle();
        #1;
        checks++;
        if (Rbusy1 !== 1'b0 || Pending_cnt !== 6'd0 || Rout1 !== 32'h55) begin
            errors++;
            $display("FAIL write_r7_clear: Rbusy1=%b Pending_cnt=%0d Rout1=%h required 0/0/55", Rbusy1, Pending_cnt, Rout1);
        end
    endtask

    task automatic test_same_reg();
        Ctrl_regWr = 1'b1; Write_import = 5'd3; Write_data = 32'hAA;
        Ctrl_issue = 1'b1; Issue_import = 5'd3;
        cycle();
        idle();
        Read_import1 = 5'd3;
        #1;
        checks++;
        if (Rout1 !== 32'hAA || Rbusy1 !== 1'b1 || Pending_cnt !== 6'd1) begin
            errors++;
            $display("FAIL same_reg_r3: Rout1=%h Rbusy1=%b Pending_cnt=%0d required aa/1/1", Rout1, Rbusy1, Pending_cnt);
        end
    endtask

    task automatic test_collision();
        logic [31:0] exp_rout2;
        logic        exp_busy1;
        logic [31:0] exp_rout1;
`ifdef REGFILE_BYPASS_EN
        exp_rout2 = 32'h1234;
        exp_busy1 = 1'b0;
        exp_rout1 = 32'hBB;
`else
        exp_rout2 = 32'h0;
        exp_busy1 = 1'b1;
        exp_rout1 = 32'hAA;
`endif
        Read_import2 = 5'd9;
        Ctrl_regWr = 1'b1; Write_import = 5'd9; Write_data = 32'h1234;
        #1;
        checks++;
        if (Rout2 !== exp_rout2 || Rbusy2 !== 1'b0) begin
            errors++;
            $display("FAIL collide_r9: Rout2=%h Rbusy2=%b required %h/0", Rout2, Rbusy2, exp_rout2);
        end
        cycle();
        // r3 is still pending from the previous test
        Read_import1 = 5'd3;
        Write_import = 5'd3; Write_data = 32'hBB;
        #1;
        checks++;
        if (Rout1 !== exp_rout1 || Rbusy1 !== exp_busy1) begin
            errors++;
            $display("FAIL collide_r3: Rout1=%h Rbusy1=%b required %h/%b", Rout1, Rbusy1, exp_rout1, exp_busy1);
        end
        cycle();
        idle();
        #1;
        checks++;
        if (Rout2 !== 32'h1234 || Rout1 !== 32'hBB || Rbusy1 !== 1'b0 || Pending_cnt !== 6'd0) begin
            errors++;
            $display("FAIL collide_after: Rout1=%h Rout2=%h Rbusy1=%b Pending_cnt=%0d required bb/1234/0/0", Rout1, Rout2, Rbusy1, Pending_cnt);
        end
    endtask

    task automatic test_diff_regs();
        Ctrl_issue = 1'b1; Issue_import = 5'd6;
        cycle();
        Issue_import = 5'd2;
        Ctrl_regWr = 1'b1; Write_import = 5'd6; Write_data = 32'h66;
        cycle();
        idle();
        Read_import1 = 5'd2;
        Read_import2 = 5'd6;
        #1;
        checks++;
        if (Pending_cnt !== 6'd1 || Rbusy1 !== 1'b1 || Rbusy2 !== 1'b0 || Rout2 !== 32'h66) begin
            errors++;
            $display("FAIL diff_regs: Pending_cnt=%0d Rbusy1=%b Rbusy2=%b Rout2=%h required 1/1/0/66", Pending_cnt, Rbusy1, Rbusy2, Rout2);
        end
    endtask

    task automatic test_fill_and_reset();
        int bad;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        cycle();
        for (int i = 1; i < 32; i++) begin
            Issue_import = 5'(i); Ctrl_issue = 1'b1;
            cycle();
        end
        Ctrl_issue = 1'b0;
        #1;
        checks++;
        if (Pending_cnt !== 6'd31) begin
            errors++;
            $display("FAIL fill_cnt: Pending_cnt=%0d required 31", Pending_cnt);
        end
        Issue_import = 5'd4; Ctrl_issue = 1'b1;
        #1;
        checks++;
        if (Issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL reissue_ready: Issue_ready=%b required 0", Issue_ready);
        end
        cycle();
        Ctrl_issue = 1'b0;
        Read_import1 = 5'd31;
        #1;
        checks++;
        if (Pending_cnt !== 6'd31 || Rbusy1 !== 1'b1) begin
            errors++;
            $display("FAIL reissue_cnt: Pending_cnt=%0d Rbusy1=%b required 31/1", Pending_cnt, Rbusy1);
        end
        Ctrl_regWr = 1'b1; Write_import = 5'd10; Write_data = 32'hCAFE;
        cycle();
        idle();
        #1;
        checks++;
        if (Pending_cnt !== 6'd30) begin
            errors++;
            $display("FAIL write_r10_cnt: Pending_cnt=%0d required 30", Pending_cnt);
        end
        // Asynchronous reset between edges, controls held active through it
        Ctrl_regWr = 1'b1; Write_import = 5'd5; Write_data = 32'h77;
        Ctrl_issue = 1'b1; Issue_import = 5'd10;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (Pending_cnt !== 6'd0) begin
            errors++;
            $display("FAIL async_rst_cnt: Pending_cnt=%0d required 0", Pending_cnt);
        end
        cycle();
        bad = 0;
        for (int a = 0; a < 32; a++) begin
            Read_import1 = 5'(a);
            Read_import2 = 5'(31 - a);
            #1;
            if (Rout1 !== 32'h0 || Rbusy1 !== 1'b0 || Rbusy2 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || Pending_cnt !== 6'd0 || Issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_clear_all: bad_regs=%0d Pending_cnt=%0d Issue_ready=%b required 0/0/1", bad, Pending_cnt, Issue_ready);
        end
        idle();
        rst = 1'b0;
        cycle();
    endtask

    initial begin
        Read_import1 = '0;
        Read_import2 = '0;
        idle();
        rst = 1'b0;
        test_reset();
        test_write_read();
        test_issue();
        test_same_reg();
        test_collision();
        test_diff_regs();
        test_fill_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
